barrel_move: RTL



---
 rtl/barrel_move_if.sv | 13 +
 rtl/barrel_move.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/barrel_move_if.sv
// Launch-controller <-> barrel motion engine link: enable/frame in, done pulse and draw position out.
// Pure wiring; timing and handshake rules live in barrel_move.
interface barrel_move_if;
    logic        en;
    logic        frame_tick;
    logic        done;
    logic        visible;
    logic [10:0] xpos;
    logic [9:0]  ypos;

    modport master (output en, frame_tick, input done, visible, xpos, ypos);
    modport slave  (input en, frame_tick, output done, visible, xpos, ypos);
endinterface

// File: rtl/barrel_move.sv
// Per-barrel motion engine: rolls along platforms, falls at edges, pulses done after the last edge.
// Latency: all outputs registered, one cycle after en/frame_tick; no backpressure, en=0 aborts at once.
module barrel_move #(
    parameter int START_X    = 80,
    parameter int LEFT_EDGE  = 64,
    parameter int RIGHT_EDGE = 960,
    parameter int H_SPEED    = 4,
    parameter int PLAT_Y0    = 200,
    parameter int PLAT_PITCH = 120,
    parameter int NUM_PLAT   = 4,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 8
) (
    input  logic         clk,
    input  logic         rst,
    barrel_move_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ROLL     = 3'd1,
        FALL     = 3'd2,
        DONE     = 3'd3,
        WAIT_CLR = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] xpos_q, xpos_d;
    logic [9:0]  ypos_q, ypos_d;
    logic [7:0]  vy_q, vy_d;
    logic [3:0]  plat_q, plat_d;
    logic        dir_left_q, dir_left_d;
    logic        visible_q, visible_d;
    logic        done_q, done_d;

    logic [11:0]        nx_r;
    logic signed [12:0] nx_l;
    logic [11:0]        vy_sum;
    logic [11:0]        vy_new;
    logic [11:0]        ny;
    logic [11:0]        plat_nxt;
    logic [11:0]        target;
    logic               edge_hit;

    // Candidate moves are computed every cycle; the FSM decides which one is committed.
    always_comb begin
        nx_r     = {1'b0, xpos_q} + 12'(H_SPEED);
        nx_l     = $signed({2'b00, xpos_q}) - $signed(13'(H_SPEED));
        vy_sum   = {4'd0, vy_q} + 12'(GRAVITY);
        vy_new   = (vy_sum > 12'(MAX_FALL)) ? 12'(MAX_FALL) : vy_sum;
        ny       = {2'b00, ypos_q} + vy_new;
        plat_nxt = {8'd0, plat_q} + 12'd1;
        target   = 12'(PLAT_Y0) + plat_nxt * 12'(PLAT_PITCH);
    end

    always_comb begin
        state_d    = state_q;
        xpos_d     = xpos_q;
        ypos_d     = ypos_q;
        vy_d       = vy_q;
        plat_d     = plat_q;
        dir_left_d = dir_left_q;
        visible_d  = visible_q;
        done_d     = 1'b0;
        edge_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                visible_d = 1'b0;
                if (bus.en) begin
                    state_d    = ROLL;
                    xpos_d     = 11'(START_X);
                    ypos_d     = 10'(PLAT_Y0);
                    plat_d     = 4'd0;
                    dir_left_d = 1'b0;
                    vy_d       = 8'd0;
                    visible_d  = 1'b1;
                end
            end

            ROLL: begin
                if (!bus.en) begin
                    state_d   = IDLE;
                    visible_d = 1'b0;
                end else if (bus.frame_tick) begin
                    if (!dir_left_q) begin
                        if (nx_r >= 12'(RIGHT_EDGE)) begin
                            xpos_d   = 11'(RIGHT_EDGE);
                            edge_hit = 1'b1;
                        end else begin
                            xpos_d = nx_r[10:0];
                        end
                    end else begin
                        // Signed compare so a step below zero still counts as reaching the edge.
                        if (nx_l <= $signed(13'(LEFT_EDGE))) begin
                            xpos_d   = 11'(LEFT_EDGE);
                            edge_hit = 1'b1;
                        end else begin
                            xpos_d = nx_l[10:0];
                        end
                    end
                    if (edge_hit) begin
                        if (plat_q < 4'(NUM_PLAT - 1)) begin
                            state_d = FALL;
                            vy_d    = 8'd0;
                        end else begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            visible_d = 1'b0;
                        end
                    end
                end
            end

            FALL: begin
                if (!bus.en) begin
                    state_d   = IDLE;
                    visible_d = 1'b0;
                end else if (bus.frame_tick) begin
                    if (ny >= target) begin
                        ypos_d     = target[9:0];
                        plat_d     = plat_q + 4'd1;
                        dir_left_d = ~dir_left_q;
                        vy_d       = 8'd0;
                        state_d    = ROLL;
                    end else begin
                        ypos_d = ny[9:0];
                        vy_d   = vy_new[7:0];
                    end
                end
            end

            DONE: begin
                visible_d = 1'b0;
                state_d   = WAIT_CLR;
            end

            WAIT_CLR: begin
                // Stale enable must drop before another launch is accepted.
                visible_d = 1'b0;
                if (!bus.en) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d   = IDLE;
                visible_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            xpos_q     <= '0;
            ypos_q     <= '0;
            vy_q       <= '0;
            plat_q     <= '0;
            dir_left_q <= 1'b0;
            visible_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            xpos_q     <= xpos_d;
            ypos_q     <= ypos_d;
            vy_q       <= vy_d;
            plat_q     <= plat_d;
            dir_left_q <= dir_left_d;
            visible_q  <= visible_d;
            done_q     <= done_d;
        end
    end

    assign bus.xpos    = xpos_q;
    assign bus.ypos    = ypos_q;
    assign bus.visible = visible_q;
    assign bus.done    = done_q;

endmodule
